frame_packer: RTL

Parametrised successor to the pixel-readout parallel-to-FIFO sampler. It takes the byte-wide digital output of the pixel chip and tracks the frame header with loss-of-lock hysteresis. On request it captures 1 frame (trigger) or a runtime-programmable number of frames (start), packs the bytes MSB-first into FIFO words, and tags each word with start-of-frame and end-of-frame flags. It sits between the chip data receiver and the readout FIFO in the pixel_config path.

---
 rtl/frame_pkg.sv | 11 +
 rtl/frame_lock_tracker.sv | 44 ++++
 rtl/frame_packer.sv | 107 ++++++++++
 3 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: shared types and constants for the frame packing readout path
package frame_pkg;
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;
  localparam logic [7:0] DEFAULT_HEADER = 8'hBC;
  function automatic int sof_bit(input int fifo_width);
    return fifo_width - 1;
  endfunction
  function automatic int eof_bit(input int fifo_width);
    return fifo_width - 2;
  endfunction
endpackage

// File: rtl/frame_lock_tracker.sv
// frame_lock_tracker: frame header lock with miss hysteresis and in-frame byte position
module frame_lock_tracker
  import frame_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int FRAME_LEN = 48,
  parameter int LOCK_MISS = 2,
  parameter logic [BYTE_W-1:0] HEADER = BYTE_W'(DEFAULT_HEADER)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BYTE_W-1:0]            fd_in,
  output logic                         locked,
  output logic [$clog2(FRAME_LEN)-1:0] pos,
  output logic                         sof
);
  localparam int PW = $clog2(FRAME_LEN);
  localparam int MW = $clog2(LOCK_MISS + 1);
  logic [MW-1:0] miss;
  logic hdr;
  assign hdr = fd_in == HEADER;
  assign sof = hdr && (!locked || pos == '0);
  always_ff @(posedge clk) begin
    if (rst) begin
      locked <= 1'b0;
      pos <= '0;
      miss <= '0;
    end else if (!locked) begin
      if (hdr) begin
        locked <= 1'b1;
        pos <= PW'(1);
      end
    end else begin
      pos <= pos == PW'(FRAME_LEN - 1) ? '0 : pos + PW'(1);
      if (pos == '0) begin
        if (hdr) miss <= '0;
        else if (miss == MW'(LOCK_MISS - 1)) begin
          locked <= 1'b0;
          miss <= '0;
        end else miss <= miss + MW'(1);
      end
    end
  end
endmodule

// File: rtl/frame_packer.sv
// frame_packer: captures header-aligned frames and packs bytes MSB-first into SOF/EOF-tagged FIFO words
module frame_packer
  import frame_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int BPW = 4,
  parameter int FIFO_WIDTH = 36,
  parameter int FRAME_LEN = 48,
  parameter logic [BYTE_W-1:0] HEADER = BYTE_W'(DEFAULT_HEADER),
  parameter int NF_W = 10,
  parameter int LOCK_MISS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  trigger,
  input  logic                  abort,
  input  logic [NF_W-1:0]       nframes,
  input  logic [BYTE_W-1:0]     fd_in,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  locked,
  output logic                  busy,
  output logic [NF_W-1:0]       frames_done,
  output logic                  ovf_err
);
  localparam int DW = BPW * BYTE_W;
  localparam int PW = $clog2(FRAME_LEN);
  state_t state, state_n;
  logic [NF_W-1:0] frames_left, fl_n;
  logic [PW-1:0] pos;
  logic [DW-1:0] sreg, packed_n;
  logic [FIFO_WIDTH-1:0] dout_n;
  logic sof, req, start_cap, take, word_done, frame_end, ovf_drop;
  frame_lock_tracker #(
    .BYTE_W(BYTE_W), .FRAME_LEN(FRAME_LEN), .LOCK_MISS(LOCK_MISS), .HEADER(HEADER)
  ) u_lock (
    .clk(clk), .rst(rst), .fd_in(fd_in), .locked(locked), .pos(pos), .sof(sof)
  );
  // A captured frame always starts at pos 0 of a locked frame, so pos doubles as the byte counter
  assign req = (start | trigger) & ~abort;
  assign packed_n = {sreg[DW-BYTE_W-1:0], fd_in};
  assign word_done = (32'(pos) % BPW) == BPW - 1;
  assign busy = state != IDLE;
  always_comb begin
    dout_n = '0;
    dout_n[DW-1:0] = packed_n;
    dout_n[sof_bit(FIFO_WIDTH)] = pos == PW'(BPW - 1);
    dout_n[eof_bit(FIFO_WIDTH)] = pos == PW'(FRAME_LEN - 1);
  end
  always_comb begin
    state_n = state;
    fl_n = abort ? '0 : start ? nframes : trigger ? NF_W'(1) : frames_left;
    start_cap = 1'b0;
    take = 1'b0;
    frame_end = 1'b0;
    ovf_drop = 1'b0;
    if (abort) state_n = IDLE;
    else begin
      unique case (state)
        IDLE: state_n = frames_left != '0 ? ARMED : IDLE;
        ARMED: begin
          if (frames_left == '0) state_n = IDLE;
          else if (sof && !fifo_full) begin
            state_n = CAPTURE;
            start_cap = 1'b1;
          end
        end
        CAPTURE: begin
          if (fifo_full) begin
            ovf_drop = 1'b1;
            state_n = ARMED;
          end else if (!locked) state_n = ARMED;
          else begin
            take = 1'b1;
            if (pos == PW'(FRAME_LEN - 1)) begin
              frame_end = 1'b1;
              if (!req && frames_left != '0) fl_n = frames_left - NF_W'(1);
              state_n = fl_n == '0 ? IDLE : ARMED;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      frames_left <= '0;
      sreg <= '0;
      fifo_wr_en <= 1'b0;
      data_out <= '0;
      frames_done <= '0;
      ovf_err <= 1'b0;
    end else begin
      state <= state_n;
      frames_left <= fl_n;
      fifo_wr_en <= take && word_done;
      if (take && word_done) data_out <= dout_n;
      if (start_cap || take) sreg <= packed_n;
      frames_done <= req ? '0 : (frame_end && frames_done != '1) ? frames_done + NF_W'(1) : frames_done;
      ovf_err <= ovf_drop | (ovf_err & ~req);
    end
  end
endmodule
